// File: rtl/lc3b_instr_encoder_pkg.sv
// Shared LC-3b encoder types: opcode enum, error code enum, field limits
// and a helper that folds range/alignment flags into an error code.
package lc3b_instr_encoder_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        ENC_OK    = 2'd0,
        ENC_RANGE = 2'd1,
        ENC_ALIGN = 2'd2,
        ENC_BOTH  = 2'd3
    } lc3b_enc_err_t;

    // Inclusive limits of the extended value accepted by each field
    localparam int IMM5_LO  = -16;
    localparam int IMM5_HI  = 15;
    localparam int OFF9_LO  = -512;
    localparam int OFF9_HI  = 510;
    localparam int OFF11_LO = -2048;
    localparam int OFF11_HI = 2046;
    localparam int BOFF6_LO = -32;
    localparam int BOFF6_HI = 31;
    localparam int WOFF6_LO = -64;
    localparam int WOFF6_HI = 62;
    localparam int SHF_HI   = 15;
    localparam int TRAP_HI  = 510;

    // Error code bit 0 flags range, bit 1 flags alignment
    function automatic lc3b_enc_err_t enc_err(input logic range_bad, input logic align_bad);
        return lc3b_enc_err_t'({align_bad, range_bad});
    endfunction

endpackage

// File: rtl/lc3b_instr_encoder_imm_check.sv
// Combinational field extractor and range/alignment checker. The selected
// field is returned left-aligned in an 11-bit vector (MSB at bit 10).
module lc3b_imm_check
    import lc3b_instr_encoder_pkg::*;
(
    input  lc3b_opcode    opcode,
    input  logic          imm_mode,
    input  lc3b_word      value,
    output logic [10:0]   field,
    output lc3b_enc_err_t err
);

    int   sval;
    int   uval;
    logic range_bad;
    logic align_bad;

    assign sval = int'($signed(value));
    assign uval = int'(value);

    // Pick the field bits for the opcode and flag out-of-range / odd values
    always_comb begin
        field     = '0;
        range_bad = 1'b0;
        align_bad = 1'b0;
        case (opcode)
            op_add, op_and: begin
                if (imm_mode) begin
                    field     = {value[4:0], 6'b0};
                    range_bad = (sval < IMM5_LO) || (sval > IMM5_HI);
                end
            end
            op_br, op_lea: begin
                field     = {value[9:1], 2'b0};
                range_bad = (sval < OFF9_LO) || (sval > OFF9_HI);
                align_bad = value[0];
            end
            op_jsr: begin
                if (imm_mode) begin
                    field     = value[11:1];
                    range_bad = (sval < OFF11_LO) || (sval > OFF11_HI);
                    align_bad = value[0];
                end
            end
            op_ldb, op_stb: begin
                field     = {value[5:0], 5'b0};
                range_bad = (sval < BOFF6_LO) || (sval > BOFF6_HI);
            end
            op_ldi, op_ldr, op_sti, op_str: begin
                field     = {value[6:1], 5'b0};
                range_bad = (sval < WOFF6_LO) || (sval > WOFF6_HI);
                align_bad = value[0];
            end
            op_shf: begin
                field     = {value[3:0], 7'b0};
                range_bad = uval > SHF_HI;
            end
            op_trap: begin
                field     = {value[8:1], 3'b0};
                range_bad = uval > TRAP_HI;
                align_bad = value[0];
            end
            default: begin
                field = '0;
            end
        endcase
        err = enc_err(range_bad, align_bad);
    end

endmodule

// File: rtl/lc3b_instr_encoder.sv
// Two-stage LC-3b instruction encoder with valid/ready handshake.
// S1 captures the request and its check result, S2 holds the packed word.
module lc3b_instr_encoder
    import lc3b_instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [2:0]  dr,
    input  logic [2:0]  sr1,
    input  logic [2:0]  sr2,
    input  logic        imm_mode,
    input  logic [1:0]  shf_da,
    input  logic [2:0]  nzp,
    input  logic [15:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] instr,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    lc3b_opcode    op_in;
    logic [10:0]   chk_field;
    lc3b_enc_err_t chk_err;

    logic          s1_valid_reg;
    lc3b_opcode    s1_op_reg;
    logic [2:0]    s1_dr_reg;
    logic [2:0]    s1_sr1_reg;
    logic [2:0]    s1_sr2_reg;
    logic          s1_imm_reg;
    logic [1:0]    s1_da_reg;
    logic [2:0]    s1_nzp_reg;
    logic [10:0]   s1_field_reg;
    lc3b_enc_err_t s1_err_reg;

    logic          s2_valid_reg;
    logic [15:0]   s2_instr_reg;
    lc3b_enc_err_t s2_err_reg;
    logic [7:0]    err_count_reg;

    logic [15:0]   instr_next;
    logic          s1_adv;
    logic          s2_adv;

    assign op_in = lc3b_opcode'(opcode);

    lc3b_imm_check u_check (
        .opcode   (op_in),
        .imm_mode (imm_mode),
        .value    (value),
        .field    (chk_field),
        .err      (chk_err)
    );

    // Ready ripples backwards; a stage may load when it is empty or draining
    assign s2_adv   = out_ready || !s2_valid_reg;
    assign s1_adv   = s2_adv || !s1_valid_reg;
    assign in_ready = s1_adv;

    // S1: capture the request fields and the check result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= op_br;
            s1_dr_reg    <= '0;
            s1_sr1_reg   <= '0;
            s1_sr2_reg   <= '0;
            s1_imm_reg   <= 1'b0;
            s1_da_reg    <= '0;
            s1_nzp_reg   <= '0;
            s1_field_reg <= '0;
            s1_err_reg   <= ENC_OK;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_op_reg    <= op_in;
                s1_dr_reg    <= dr;
                s1_sr1_reg   <= sr1;
                s1_sr2_reg   <= sr2;
                s1_imm_reg   <= imm_mode;
                s1_da_reg    <= shf_da;
                s1_nzp_reg   <= nzp;
                s1_field_reg <= chk_field;
                s1_err_reg   <= chk_err;
            end
        end
    end

    // Pack the instruction word from the S1 fields
    always_comb begin
        instr_next = '0;
        case (s1_op_reg)
            op_br:
                instr_next = {4'b0000, s1_nzp_reg, s1_field_reg[10:2]};
            op_add, op_and:
                instr_next = s1_imm_reg
                    ? {s1_op_reg, s1_dr_reg, s1_sr1_reg, 1'b1, s1_field_reg[10:6]}
                    : {s1_op_reg, s1_dr_reg, s1_sr1_reg, 3'b000, s1_sr2_reg};
            op_ldb, op_stb, op_ldr, op_str, op_ldi, op_sti:
                instr_next = {s1_op_reg, s1_dr_reg, s1_sr1_reg, s1_field_reg[10:5]};
            op_jsr:
                instr_next = s1_imm_reg
                    ? {4'b0100, 1'b1, s1_field_reg}
                    : {4'b0100, 3'b000, s1_sr1_reg, 6'b000000};
            op_rti:
                instr_next = 16'h8000;
            op_not:
                instr_next = {4'b1001, s1_dr_reg, s1_sr1_reg, 6'b111111};
            op_jmp:
                instr_next = {4'b1100, 3'b000, s1_sr1_reg, 6'b000000};
            op_shf:
                instr_next = {4'b1101, s1_dr_reg, s1_sr1_reg, s1_da_reg, s1_field_reg[10:7]};
            op_lea:
                instr_next = {4'b1110, s1_dr_reg, s1_field_reg[10:2]};
            op_trap:
                instr_next = {4'b1111, 4'b0000, s1_field_reg[10:3]};
            default:
                instr_next = '0;
        endcase
    end

    // S2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= '0;
            s2_err_reg   <= ENC_OK;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_instr_reg <= instr_next;
                s2_err_reg   <= s1_err_reg;
            end
        end
    end

    // Count delivered errored instructions, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (s2_valid_reg && out_ready && (s2_err_reg != ENC_OK) && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign out_valid = s2_valid_reg;
    assign instr     = s2_instr_reg;
    assign err_code  = s2_err_reg;
    assign err       = (s2_err_reg != ENC_OK);
    assign err_count = err_count_reg;

endmodule
